// File: rtl/uart_tx_vo_pkg.sv
// Shared definitions for the variable-oversampling UART transmitter:
// FSM encoding, frame geometry and the line-level helper.
package uart_tx_vo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    // Serial line level driven while in a given state.
    function automatic logic line_level(input tx_state_e st, input logic lsb);
        logic lvl;
        case (st)
            ST_START: lvl = 1'b0;
            ST_DATA:  lvl = lsb;
            default:  lvl = 1'b1;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/uart_tx_vo_bit_timer.sv
// Bit-period timer: counts 0..R-1 with R latched on load and raises a
// one-cycle tick on the last cycle of each bit period.
module uart_tx_vo_bit_timer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [N-1:0] ratio,
    output logic         tick
);

    localparam logic [N-1:0] ONE_C = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] ratio_q;
    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;
    logic         last_s;

    assign last_s = (cnt_q == (ratio_q - ONE_C));
    assign tick   = en & last_s;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last_s ? '0 : (cnt_q + ONE_C);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            ratio_q <= ONE_C;
        end else begin
            cnt_q <= cnt_d;
            if (load) begin
                ratio_q <= ratio;
            end
        end
    end

endmodule

// File: rtl/uart_tx_vo.sv
// 8N1 UART transmitter with run-time oversampling ratio and a one-byte
// holding register so consecutive frames run without an idle gap.
module uart_tx_vo
    import uart_tx_vo_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in,
    input  logic         clk_in,
    input  logic [N-1:0] o,
    output logic         out,
    output logic         busy,
    output logic         full,
    output logic         ovf
);

    localparam logic [N-1:0] ONE_C = {{(N-1){1'b0}}, 1'b1};

    tx_state_e    state_q, state_d;
    logic [2:0]   bit_q, bit_d;
    logic [7:0]   shift_q, shift_d;
    logic [7:0]   hold_q, hold_d;
    logic         full_q, full_d;
    logic         ovf_q, ovf_d;
    logic         out_q, out_d;
    logic         busy_q, busy_d;
    logic         clk_in_q;
    logic         write_s;
    logic         load_s;
    logic         tick_s;
    logic [N-1:0] ratio_s;

    assign write_s = clk_in & ~clk_in_q;
    assign ratio_s = (o == '0) ? ONE_C : o;
    // A new frame starts from IDLE, or straight out of a finishing stop bit.
    assign load_s  = full_q & ((state_q == ST_IDLE) | ((state_q == ST_STOP) & tick_s));

    uart_tx_vo_bit_timer #(.N(N)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .en    (state_q != ST_IDLE),
        .ratio (ratio_s),
        .tick  (tick_s)
    );

    always_comb begin
        hold_d = hold_q;
        ovf_d  = ovf_q;
        full_d = load_s ? 1'b0 : full_q;
        if (write_s) begin
            if (!full_q || load_s) begin
                hold_d = in;
                full_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (load_s) begin
                    state_d = ST_START;
                    shift_d = hold_q;
                    bit_d   = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (load_s) begin
                    state_d = ST_START;
                    shift_d = hold_q;
                    bit_d   = 3'd0;
                end else if (tick_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        out_d  = line_level(state_d, shift_d[0]);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            hold_q   <= 8'h00;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            out_q    <= 1'b1;
            busy_q   <= 1'b0;
            clk_in_q <= 1'b0;
        end else begin
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            hold_q   <= hold_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            clk_in_q <= clk_in;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign full = full_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_uart_tx_vo.sv
// Directed self-checking bench for uart_tx_vo with a mid-bit sampling
// receiver model on the serial line.
module tb_uart_tx_vo;
    import uart_tx_vo_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   din;
    logic         clk_in;
    logic [N-1:0] o_v;
    logic         out, busy, full, ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] rx_q[$];
    int         rx_r         = 8;
    logic       rx_en        = 1'b0;
    int         rx_frame_err = 0;
    logic [9:0] rx_bits;

    uart_tx_vo #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .in     (din),
        .clk_in (clk_in),
        .o      (o_v),
        .out    (out),
        .busy   (busy),
        .full   (full),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic exp_bit(input logic [7:0] b, input int j);
        logic [7:0] t;
        t = b;
        if (j == 0) return 1'b0;
        if (j >= 9) return 1'b1;
        return t[j-1];
    endfunction

    // Receiver model: detect start, then sample each bit near its centre.
    always begin
        @(negedge clk);
        if (rx_en && out === 1'b0) begin
            repeat ((rx_r - 1) / 2) @(negedge clk);
            rx_bits[0] = out;
            for (int j = 1; j < 10; j++) begin
                repeat (rx_r) @(negedge clk);
                rx_bits[j] = out;
            end
            if (rx_bits[0] == 1'b0 && rx_bits[9] == 1'b1) rx_q.push_back(rx_bits[8:1]);
            else rx_frame_err++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests_run++;
        if ({out, busy, full, ovf} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_async: out/busy/full/ovf=%b required 1000", {out, busy, full, ovf});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            tests_run++;
            if ({out, busy, full, ovf} !== 4'b1000) begin
                tests_failed++;
                $display("FAIL reset_idle c=%0d: out/busy/full/ovf=%b required 1000", c, {out, busy, full, ovf});
            end
        end
    endtask

    task automatic test_single();
        o_v = 4'd5;
        @(negedge clk); din = 8'hA5; clk_in = 1'b1;
        @(negedge clk); clk_in = 1'b0;
        tests_run++;
        if ({out, busy, full} !== 3'b101) begin
            tests_failed++;
            $display("FAIL single_capture: out/busy/full=%b required 101", {out, busy, full});
        end
        for (int i = 0; i < FRAME_BITS * 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (out !== exp_bit(8'hA5, i / 5) || busy !== 1'b1 || (i == 0 && full !== 1'b0)) begin
                tests_failed++;
                $display("FAIL single_frame i=%0d: out=%b busy=%b full=%b required out=%b busy=1",
                         i, out, busy, full, exp_bit(8'hA5, i / 5));
            end
        end
        @(negedge clk);
        tests_run++;
        if ({out, busy, full} !== 3'b100) begin
            tests_failed++;
            $display("FAIL single_end: out/busy/full=%b required 100", {out, busy, full});
        end
    endtask

    task automatic test_back_to_back();
        o_v = 4'd5;
        @(negedge clk); din = 8'h3C; clk_in = 1'b1;
        @(negedge clk); clk_in = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            tests_run++;
            if (out !== exp_bit(8'h3C, i / 5) || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_frame1 i=%0d: out=%b busy=%b required out=%b busy=1",
                         i, out, busy, exp_bit(8'h3C, i / 5));
            end
            if (i == 20) begin
                tests_run++;
                if (full !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_full_held: full=%b required 1", full);
                end
            end
            if (i == 10) begin din = 8'hC3; o_v = 4'd8; clk_in = 1'b1; end
            if (i == 11) clk_in = 1'b0;
        end
        for (int j = 0; j < 80; j++) begin
            @(negedge clk);
            tests_run++;
            if (out !== exp_bit(8'hC3, j / 8) || busy !== 1'b1 || (j == 0 && full !== 1'b0)) begin
                tests_failed++;
                $display("FAIL b2b_frame2 j=%0d: out=%b busy=%b full=%b required out=%b busy=1",
                         j, out, busy, full, exp_bit(8'hC3, j / 8));
            end
        end
        @(negedge clk);
        tests_run++;
        if ({out, busy, full} !== 3'b100) begin
            tests_failed++;
            $display("FAIL b2b_end: out/busy/full=%b required 100", {out, busy, full});
        end
    endtask

    task automatic test_overflow_held();
        int t;
        int busy_cnt;
        o_v = 4'd3; rx_r = 3; rx_en = 1'b1;
        repeat (60) @(negedge clk);
        rx_q.delete();
        @(negedge clk); din = 8'h55; clk_in = 1'b1;
        @(negedge clk); clk_in = 1'b0;
        repeat (3) @(negedge clk);
        din = 8'h11; clk_in = 1'b1;
        @(negedge clk); clk_in = 1'b0;
        tests_run++;
        if ({full, ovf} !== 2'b10) begin
            tests_failed++;
            $display("FAIL ovf_accept: full/ovf=%b required 10", {full, ovf});
        end
        @(negedge clk); din = 8'h22; clk_in = 1'b1;
        @(negedge clk); clk_in = 1'b0;
        tests_run++;
        if ({full, ovf} !== 2'b11) begin
            tests_failed++;
            $display("FAIL ovf_drop: full/ovf=%b required 11", {full, ovf});
        end
        t = 0;
        while ((busy !== 1'b0 || full !== 1'b0) && t < 200) begin @(negedge clk); t++; end
        repeat (5) @(negedge clk);
        tests_run++;
        if (t >= 200 || rx_q.size() != 2 || rx_q[0] !== 8'h55 || rx_q[1] !== 8'h11 || ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_frames: count=%0d first=%h second=%h ovf=%b required count=2 55 11 ovf=1",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, (rx_q.size() > 1) ? rx_q[1] : 8'hxx, ovf);
        end
        o_v = 4'd1; rx_r = 1;
        repeat (5) @(negedge clk);
        rx_q.delete();
        din = 8'h5A; clk_in = 1'b1;
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (c == 29) clk_in = 1'b0;
        end
        tests_run++;
        if (busy_cnt != 10 || rx_q.size() != 1 || ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL held_strobe: busy_cycles=%0d frames=%0d ovf=%b required 10 1 1",
                     busy_cnt, rx_q.size(), ovf);
        end
        tests_run++;
        if (rx_q.size() > 0 && rx_q[0] !== 8'h5A) begin
            tests_failed++;
            $display("FAIL held_data: got %h required 5a", rx_q[0]);
        end
    endtask

    task automatic test_reset_mid();
        rx_en = 1'b0;
        repeat (20) @(negedge clk);
        o_v = 4'd4;
        @(negedge clk); din = 8'hF0; clk_in = 1'b1;
        @(negedge clk); clk_in = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == 2) begin din = 8'h0F; clk_in = 1'b1; end
            if (i == 3) clk_in = 1'b0;
        end
        tests_run++;
        if ({out, busy, full} !== 3'b011) begin
            tests_failed++;
            $display("FAIL mid_before: out/busy/full=%b required 011", {out, busy, full});
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({out, busy, full, ovf} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL mid_reset: out/busy/full/ovf=%b required 1000", {out, busy, full, ovf});
        end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        o_v = 4'd0;
        din = 8'hFF; clk_in = 1'b1;
        @(negedge clk); clk_in = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            tests_run++;
            if (out !== ((i == 0 || i == 10) ? (i == 10) : 1'b1) || busy !== (i < 10)) begin
                tests_failed++;
                $display("FAIL o_zero i=%0d: out=%b busy=%b required out=%b busy=%b",
                         i, out, busy, (i == 0) ? 1'b0 : 1'b1, (i < 10));
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] vec [16];
        int t;
        vec = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h3C, 8'hC3,
                8'h7E, 8'h81, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        o_v = 4'd8; rx_r = 8; rx_en = 1'b1;
        repeat (20) @(negedge clk);
        rx_q.delete();
        rx_frame_err = 0;
        for (int k = 0; k < 16; k++) begin
            t = 0;
            while (full !== 1'b0 && t < 500) begin @(negedge clk); t++; end
            din = vec[k]; clk_in = 1'b1;
            @(negedge clk); clk_in = 1'b0;
        end
        t = 0;
        while (rx_q.size() < 16 && t < 3000) begin @(negedge clk); t++; end
        tests_run++;
        if (rx_q.size() != 16 || rx_frame_err != 0) begin
            tests_failed++;
            $display("FAIL loop_count: frames=%0d errors=%0d required 16 0", rx_q.size(), rx_frame_err);
        end
        for (int k = 0; k < 16; k++) begin
            if (k < rx_q.size()) begin
                tests_run++;
                if (rx_q[k] !== vec[k]) begin
                    tests_failed++;
                    $display("FAIL loop_byte%0d: got %h required %h", k, rx_q[k], vec[k]);
                end
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        din    = 8'h00;
        clk_in = 1'b0;
        o_v    = 4'd5;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow_held();
        test_reset_mid();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
